// File: rtl/stopwatch_core.sv
// stopwatch_core: centisecond stopwatch time base with start/stop, lap-freeze and clear buttons
module stopwatch_core #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100,
  parameter int MAX_CS  = 599999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  output logic [19:0] value,
  output logic        running,
  output logic        lap_active,
  output logic        tick
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;
  state_t state, state_n;
  logic [2:0] s1, s2, prev, ev;
  logic [PW-1:0] presc, presc_n;
  logic [19:0] count, count_n, count_t, lap_reg, lap_n;
  logic do_clr, do_ss, do_lap;
  // button bits are {clear, lap, start_stop}; priority resolved before the FSM sees them
  assign ev = s2 & ~prev;
  assign do_clr = ev[2];
  assign do_ss = ev[0] & ~ev[2];
  assign do_lap = ev[1] & ~ev[0] & ~ev[2];
  assign running = state == RUN || state == LAP;
  assign lap_active = state == LAP;
  assign tick = running && presc == PW'(DIV - 1);
  assign count_t = tick ? (count == 20'(MAX_CS) ? '0 : count + 20'd1) : count;
  assign value = lap_active ? lap_reg : count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
      presc <= '0;
      count <= '0;
      lap_reg <= '0;
    end else begin
      state <= state_n;
      s1 <= {clear, lap, start_stop};
      s2 <= s1;
      prev <= s2;
      presc <= presc_n;
      count <= count_n;
      lap_reg <= lap_n;
    end
  end
  always_comb begin
    state_n = state;
    count_n = count_t;
    lap_n = lap_reg;
    presc_n = tick ? '0 : running ? presc + PW'(1) : presc;
    case (state)
      IDLE: state_n = do_ss ? RUN : IDLE;
      RUN: begin
        if (do_ss) state_n = PAUSE;
        else if (do_lap) begin
          state_n = LAP;
          lap_n = count_t;
        end
      end
      LAP: state_n = do_ss ? PAUSE : do_lap ? RUN : LAP;
      PAUSE: begin
        if (do_clr) begin
          state_n = IDLE;
          count_n = '0;
          presc_n = '0;
          lap_n = '0;
        end else if (do_ss) state_n = RUN;
      end
    endcase
  end
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: elapsed-run-time model plus directed button scenarios and a small wrap instance
module tb_stopwatch_core;
  localparam int DIV = 10;
  localparam int MAXM = 599999;
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;
  logic clk = 0, rst = 1, start_stop = 0, lap = 0, clear = 0;
  logic [19:0] value, w_value;
  logic running, lap_active, tick, w_ss = 0, w_zero = 0, w_running, w_lap_active, w_tick;
  int checks = 0, errors = 0;
  bit en = 0;
  int mmode, rc, lapv;
  logic [2:0] h1, h2, h3;

  stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100), .MAX_CS(MAXM)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .lap(lap), .clear(clear),
    .value(value), .running(running), .lap_active(lap_active), .tick(tick));
  stopwatch_core #(.CLK_HZ(200), .TICK_HZ(100), .MAX_CS(19)) wdut (
    .clk(clk), .rst(rst), .start_stop(w_ss), .lap(w_zero), .clear(w_zero),
    .value(w_value), .running(w_running), .lap_active(w_lap_active), .tick(w_tick));

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", n, a, e, $time);
    end
  endtask

  // model: displayed time is elapsed running cycles / DIV; buttons act 3 edges after going high
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mmode <= M_IDLE; rc <= 0; lapv <= 0; h1 <= 0; h2 <= 0; h3 <= 0;
    end else begin : mdl
      logic [2:0] e;
      int m, r, lv, cur;
      e = h2 & ~h3;
      m = mmode; r = rc; lv = lapv;
      if (m == M_RUN || m == M_LAP) r = r + 1;
      cur = (r / DIV) % (MAXM + 1);
      if (e[2]) begin
        if (m == M_PAUSE) begin m = M_IDLE; r = 0; lv = 0; end
      end else if (e[0]) m = (m == M_IDLE || m == M_PAUSE) ? M_RUN : M_PAUSE;
      else if (e[1]) begin
        if (m == M_RUN) begin m = M_LAP; lv = cur; end
        else if (m == M_LAP) m = M_RUN;
      end
      mmode <= m; rc <= r; lapv <= lv;
      h3 <= h2; h2 <= h1; h1 <= {clear, lap, start_stop};
    end
  end

  always @(negedge clk) if (en) begin
    chk("value", int'(value), mmode == M_LAP ? lapv : (rc / DIV) % (MAXM + 1));
    chk("running", int'(running), int'(mmode == M_RUN || mmode == M_LAP));
    chk("lap_active", int'(lap_active), int'(mmode == M_LAP));
    chk("tick", int'(tick), int'((mmode == M_RUN || mmode == M_LAP) && rc % DIV == DIV - 1));
  end

  task automatic press(input logic [2:0] m);
    @(negedge clk); #2 {clear, lap, start_stop} = m;
    repeat (3) @(posedge clk);
    #1 {clear, lap, start_stop} = '0;
  endtask

  task automatic wait_val(input int v);
    int n = 0;
    do begin @(negedge clk); n++; end while (int'(value) != v && n < 2000);
    chk("wait_val_timeout", int'(value), v);
  endtask

  initial begin
    int n, mx;
    #1;
    chk("rst_value", int'(value), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_lap", int'(lap_active), 0);
    chk("rst_tick", int'(tick), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    en = 1;
    press(3'b001);
    repeat (250) @(posedge clk);
    @(negedge clk);
    chk("start_value", int'(value), 25);
    chk("start_running", int'(running), 1);
    wait_val(30);
    press(3'b010);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("lap_hold", int'(value), 30);
    chk("lap_active", int'(lap_active), 1);
    press(3'b010);
    @(negedge clk);
    chk("lap_release", int'(value), 40);
    n = 0;
    repeat (100) begin @(negedge clk); n += int'(tick); end
    chk("tick_count", n, 10);
    press(3'b100);
    press(3'b001);
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("pause_hold", int'(value), 51);
    chk("pause_running", int'(running), 0);
    press(3'b100);
    @(negedge clk);
    chk("clear_value", int'(value), 0);
    chk("clear_running", int'(running), 0);
    @(negedge clk); #2 start_stop = 1;
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("held_value", int'(value), 4);
    chk("held_running", int'(running), 1);
    start_stop = 0;
    repeat (5) @(posedge clk);
    press(3'b011);
    @(negedge clk);
    chk("sim_ss_lap_running", int'(running), 0);
    chk("sim_ss_lap_lap", int'(lap_active), 0);
    repeat (2) @(posedge clk);
    press(3'b101);
    @(negedge clk);
    chk("sim_clr_ss_value", int'(value), 0);
    chk("sim_clr_ss_running", int'(running), 0);
    repeat (2) @(posedge clk);
    press(3'b001);
    wait_val(37);
    #2 rst = 1;
    #1;
    chk("async_rst_value", int'(value), 0);
    chk("async_rst_running", int'(running), 0);
    chk("async_rst_lap", int'(lap_active), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk); #2 w_ss = 1;
    repeat (3) @(posedge clk);
    #1 w_ss = 0;
    n = 0; mx = 0;
    do begin
      @(negedge clk); n++;
      if (int'(w_value) > mx) mx = int'(w_value);
    end while (int'(w_value) != 19 && n < 200);
    chk("wrap_reach_max", int'(w_value), 19);
    n = 0;
    while (!w_tick && n < 5) begin @(negedge clk); n++; end
    chk("wrap_tick_seen", int'(w_tick), 1);
    @(negedge clk);
    chk("wrap_zero", int'(w_value), 0);
    chk("wrap_running", int'(w_running), 1);
    chk("wrap_max", mx, 19);
    en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
